// File: rtl/knn_vote.sv
// Keeps the K nearest (distance, type) samples sorted and majority-votes their types after L samples.
// Latency: insertion same cycle; result pulses K+1 cycles after the L-th sample edge.
// Backpressure: none; samples arriving while voting are dropped and flagged as overrun.
module knn_vote #(
    parameter int K      = 3,
    parameter int L      = 8,
    parameter int TYPE_W = 4,
    parameter int DIST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DIST_W-1:0] sample_dist,
    input  logic [TYPE_W-1:0] sample_type,
    output logic [TYPE_W-1:0] inferred_type,
    output logic              inference_done,
    output logic [DIST_W-1:0] nearest_dist,
    output logic              busy,
    output logic              overrun
);
    localparam int PW = $clog2(K + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(L + 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_VOTE    = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DIST_W-1:0] dist_q [K];
    logic [DIST_W-1:0] dist_d [K];
    logic [TYPE_W-1:0] type_q [K];
    logic [TYPE_W-1:0] type_d [K];
    logic [K-1:0]      vld_q, vld_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     vidx_q, vidx_d;
    logic [IW-1:0]     best_idx_q, best_idx_d;
    logic [PW-1:0]     best_cnt_q, best_cnt_d;
    logic [TYPE_W-1:0] inferred_type_q, inferred_type_d;
    logic [DIST_W-1:0] nearest_dist_q, nearest_dist_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [PW-1:0]     ins_pos;
    logic [PW-1:0]     cur_cnt;

    always_comb begin
        state_d         = state_q;
        vld_d           = vld_q;
        cnt_d           = cnt_q;
        vidx_d          = vidx_q;
        best_idx_d      = best_idx_q;
        best_cnt_d      = best_cnt_q;
        inferred_type_d = inferred_type_q;
        nearest_dist_d  = nearest_dist_q;
        done_d          = 1'b0;
        overrun_d       = overrun_q;
        for (int i = 0; i < K; i++) begin
            dist_d[i] = dist_q[i];
            type_d[i] = type_q[i];
        end

        // Counting entries <= new distance places equal distances after older ones.
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && (dist_q[i] <= sample_dist)) ins_pos = ins_pos + PW'(1);
        end

        cur_cnt = '0;
        for (int j = 0; j < K; j++) begin
            if (vld_q[j] && (type_q[j] == type_q[vidx_q])) cur_cnt = cur_cnt + PW'(1);
        end

        if (clear) begin
            state_d    = ST_COLLECT;
            vld_d      = '0;
            cnt_d      = '0;
            vidx_d     = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (sample_valid) begin
                        if (ins_pos < PW'(K)) begin
                            for (int i = K - 1; i > 0; i--) begin
                                if (PW'(i) > ins_pos) begin
                                    dist_d[i] = dist_q[i-1];
                                    type_d[i] = type_q[i-1];
                                    vld_d[i]  = vld_q[i-1];
                                end else if (PW'(i) == ins_pos) begin
                                    dist_d[i] = sample_dist;
                                    type_d[i] = sample_type;
                                    vld_d[i]  = 1'b1;
                                end
                            end
                            if (ins_pos == '0) begin
                                dist_d[0] = sample_dist;
                                type_d[0] = sample_type;
                                vld_d[0]  = 1'b1;
                            end
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(L - 1)) state_d = ST_VOTE;
                    end
                end
                ST_VOTE: begin
                    // Strict compare: on equal counts the nearer neighbour keeps the win.
                    if (vld_q[vidx_q] && (cur_cnt > best_cnt_q)) begin
                        best_idx_d = vidx_q;
                        best_cnt_d = cur_cnt;
                    end
                    if (vidx_q == IW'(K - 1)) begin
                        inferred_type_d = type_q[best_idx_d];
                        nearest_dist_d  = dist_q[0];
                        done_d          = 1'b1;
                        state_d         = ST_RESULT;
                    end else begin
                        vidx_d = vidx_q + IW'(1);
                    end
                    if (sample_valid) overrun_d = 1'b1;
                end
                ST_RESULT: begin
                    vld_d      = '0;
                    cnt_d      = '0;
                    vidx_d     = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
                    state_d    = ST_COLLECT;
                    if (sample_valid) overrun_d = 1'b1;
                end
                default: state_d = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_COLLECT;
            vld_q           <= '0;
            cnt_q           <= '0;
            vidx_q          <= '0;
            best_idx_q      <= '0;
            best_cnt_q      <= '0;
            inferred_type_q <= '0;
            nearest_dist_q  <= '1;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                type_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            vld_q           <= vld_d;
            cnt_q           <= cnt_d;
            vidx_q          <= vidx_d;
            best_idx_q      <= best_idx_d;
            best_cnt_q      <= best_cnt_d;
            inferred_type_q <= inferred_type_d;
            nearest_dist_q  <= nearest_dist_d;
            done_q          <= done_d;
            overrun_q       <= overrun_d;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                type_q[i] <= type_d[i];
            end
        end
    end

    assign inferred_type  = inferred_type_q;
    assign inference_done = done_q;
    assign nearest_dist   = nearest_dist_q;
    assign busy           = (state_q != ST_COLLECT);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_knn_vote.sv
// Directed and randomized bench for knn_vote against a queue-based nearest-neighbour model.
module tb_knn_vote;
    localparam int K  = 3;
    localparam int L  = 5;
    localparam int TW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          sample_valid;
    logic [DW-1:0] sample_dist;
    logic [TW-1:0] sample_type;
    logic [TW-1:0] inferred_type;
    logic          inference_done;
    logic [DW-1:0] nearest_dist;
    logic          busy;
    logic          overrun;

    knn_vote #(.K(K), .L(L), .TYPE_W(TW), .DIST_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .sample_dist    (sample_dist),
        .sample_type    (sample_type),
        .inferred_type  (inferred_type),
        .inference_done (inference_done),
        .nearest_dist   (nearest_dist),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned d;
        int unsigned t;
    } ent_t;
    ent_t model_q[$];
    int unsigned last_type;
    int unsigned last_dist;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keep the K smallest distances; equal distances stay in arrival order.
    task automatic model_insert(input int unsigned d, input int unsigned t);
        ent_t e;
        int   pos;
        e.d = d;
        e.t = t;
        pos = model_q.size();
        for (int i = 0; i < model_q.size(); i++) begin
            if (model_q[i].d > d) begin
                pos = i;
                break;
            end
        end
        model_q.insert(pos, e);
        if (model_q.size() > K) void'(model_q.pop_back());
    endtask

    function automatic int unsigned model_vote();
        int unsigned best_t;
        int          best_c;
        int          c;
        best_t = model_q[0].t;
        best_c = 0;
        for (int i = 0; i < model_q.size(); i++) begin
            c = 0;
            for (int j = 0; j < model_q.size(); j++)
                if (model_q[j].t == model_q[i].t) c++;
            if (c > best_c) begin
                best_c = c;
                best_t = model_q[i].t;
            end
        end
        return best_t;
    endfunction

    task automatic drive_only(input int unsigned d, input int unsigned t);
        sample_valid = 1'b1;
        sample_dist  = d;
        sample_type  = TW'(t);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic feed(input int unsigned d, input int unsigned t);
        drive_only(d, t);
        model_insert(d, t);
    endtask

    // Called just after the L-th sample edge minus 'pre' VOTE cycles already spent.
    task automatic expect_result(input string tag, input int pre);
        int unsigned exp_t;
        int unsigned exp_d;
        exp_t = model_vote();
        exp_d = model_q[0].d;
        if (pre == 0) begin
            check({tag, "_busy_vote"}, 32'(busy), 32'd1);
            check({tag, "_done_early"}, 32'(inference_done), 32'd0);
        end
        for (int i = 0; i < K - 1 - pre; i++) begin
            tick();
            check({tag, "_done_early"}, 32'(inference_done), 32'd0);
            check({tag, "_busy_vote"}, 32'(busy), 32'd1);
        end
        tick();
        check({tag, "_done"}, 32'(inference_done), 32'd1);
        check({tag, "_type"}, 32'(inferred_type), exp_t);
        check({tag, "_nearest"}, nearest_dist, exp_d);
        check({tag, "_busy_result"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_done_single"}, 32'(inference_done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        last_type = exp_t;
        last_dist = exp_d;
        model_q.delete();
    endtask

    initial begin
        rst          = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_dist  = '0;
        sample_type  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_type", 32'(inferred_type), 32'd0);
        check("rst_done", 32'(inference_done), 32'd0);
        check("rst_nearest", nearest_dist, 32'hFFFF_FFFF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        feed(40, 2); feed(10, 1); feed(30, 1); feed(20, 2); feed(50, 3);
        expect_result("basic", 0);

        feed(5, 7); feed(6, 4); feed(9, 9); feed(100, 4); feed(200, 7);
        expect_result("tiebreak", 0);

        feed(8, 1); feed(8, 2); feed(8, 3); feed(8, 2); feed(8, 2);
        expect_result("equal", 0);

        feed(12, 3); feed(4, 2); feed(7, 3); feed(30, 1); feed(2, 2);
        drive_only(0, 9);
        check("ovr_set", 32'(overrun), 32'd1);
        expect_result("ovr", 1);
        feed(11, 1); feed(3, 5); feed(6, 5); feed(9, 1); feed(15, 1);
        expect_result("ovr2", 0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        check("clear_keeps_type", 32'(inferred_type), last_type);
        check("clear_keeps_dist", nearest_dist, last_dist);

        drive_only(0, 9); drive_only(0, 9); drive_only(0, 9);
        clear        = 1'b1;
        sample_valid = 1'b1;
        sample_dist  = 0;
        sample_type  = 4'd9;
        tick();
        clear        = 1'b0;
        sample_valid = 1'b0;
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_done", 32'(inference_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        feed(1, 6); feed(2, 6); feed(3, 5); feed(4, 5); feed(5, 5);
        expect_result("abort", 0);

        feed(3, 1); feed(1, 2); feed(2, 2); feed(9, 4); feed(7, 4);
        tick();
        check("vclear_busy_pre", 32'(busy), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_q.delete();
        check("vclear_busy", 32'(busy), 32'd0);
        for (int i = 0; i < K + 2; i++) begin
            tick();
            check("vclear_nodone", 32'(inference_done), 32'd0);
        end
        check("vclear_keeps_type", 32'(inferred_type), last_type);

        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < L; s++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                feed($urandom_range(0, 20), $urandom_range(0, 3));
            end
            expect_result("random", 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
# knn_vote

Final stage of the KNN datapath. It consumes one (distance, training type) pair per training sample from the distance stage and keeps the K smallest distances in a sorted list. After L samples it takes a majority vote over the kept types and returns `inferred_type` with a one-cycle `inference_done` pulse to memory control, which writes the result back. The block then clears itself for the next input vector.

## Interface
- `K`, default 3: neighbours kept and voted; range 1..16.
- `L`, default 8: training samples per inference; must be ≥1.
- `TYPE_W`, default 4: class label width.
- `DIST_W`, default 32: unsigned distance width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `clear`  in  1  abort the current inference and empty the list; takes effect at the next edge.
- `sample_valid`  in  1  one-cycle strobe; the sample is present this cycle.
- `sample_dist`  in  DIST_W  distance of the sample (unsigned).
- `sample_type`  in  TYPE_W  training type of the sample.
- `inferred_type`  out  TYPE_W  voted class; held until the next result.
- `inference_done`  out  1  one-cycle pulse; `inferred_type` is valid this cycle.
- `nearest_dist`  out  DIST_W  distance of list entry 0 at vote time; held with `inferred_type`.
- `busy`  out  1  high in VOTE and RESULT.
- `overrun`  out  1  sticky; a sample arrived in VOTE or RESULT and was dropped. Cleared only by reset or `clear`.

## Operation
- Storage:
  - K entries of {dist, type, valid}.
  - Sample counter, width $clog2(L+1).
  - Vote index, best index and best count.
- States: COLLECT, VOTE, RESULT. Reset enters COLLECT with all entries invalid and the counter at 0.
- COLLECT, on `sample_valid`:
  - Insertion position p = number of valid entries with dist ≤ `sample_dist`. Ties keep the older entry ahead, so insertion is stable.
  - If p < K: entries p..K-2 shift down one place, the entry at K-1 falls off, and the new sample is written at p.
  - If p == K (list full and the new distance is largest): the sample is discarded but still counted.
  - Counter increments. When the accepted sample is the L-th, go to VOTE next cycle.
- VOTE: runs exactly K cycles, idx = 0..K-1.
  - For entry idx, if valid: count = number of valid entries whose type equals entry idx's type (K comparators).
  - If count > best count (strict), update best index and best count. Because the comparison is strict, a tie resolves to the nearer neighbour.
  - Invalid entries are skipped. This only happens when L < K.
- RESULT, one cycle:
  - Drive `inference_done` = 1.
  - Load `inferred_type` from the type of the best entry and `nearest_dist` from entry 0's dist.
  - Invalidate all entries, zero the counter and vote registers, return to COLLECT.
- `clear`: from any state, go to COLLECT, empty the list, zero the counter, deassert `overrun`. `inferred_type` and `nearest_dist` keep their values. No `inference_done` is produced.
- A sample in VOTE or RESULT is ignored and sets `overrun`.
- Simultaneous `clear` and `sample_valid`: `clear` wins and the sample is dropped. `overrun` is not set.

## Timing
- Reset values:
  - `inferred_type` = 0, `inference_done` = 0, `nearest_dist` = all ones.
  - `busy` = 0, `overrun` = 0.
  - State COLLECT, list empty.
- Throughput: one sample per cycle in COLLECT with no backpressure. Insertion completes in the accepting cycle.
- Latency: L-th sample accepted at edge t. VOTE occupies cycles t+1..t+K. `inference_done` is high during cycle t+K+1. COLLECT accepts samples again from cycle t+K+2.
- `busy` is high from cycle t+1 through t+K+1 inclusive.
- `inference_done` is never high for two consecutive cycles.

## Test plan
- Reset and outputs: hold `rst` = 0 for 2 cycles, then release with K=3, L=5. Required: all outputs at their reset values, `busy` = 0.
- Basic vote: dist/type pairs 40/2, 10/1, 30/1, 20/2, 50/3 on consecutive cycles. Required:
  - list = {10/1, 20/2, 30/1};
  - `inferred_type` = 1, `nearest_dist` = 10;
  - `inference_done` pulses exactly 4 cycles after the 5th sample's edge.
- Tie-break: pairs 5/7, 6/4, 9/9, 100/4, 200/7. Required: list {5/7, 6/4, 9/9}, each type counted once, `inferred_type` = 7 (the nearest).
- Equal distances: five samples all with dist 8, types 1,2,3,2,2. Required: list holds types {1,2,3} in arrival order, `inferred_type` = 1.
- Overrun: start a 6th sample one cycle after the 5th, while in VOTE. Required:
  - `overrun` = 1 and the result is unchanged;
  - after the result, the next 5 samples produce a second pulse;
  - `clear` then returns `overrun` to 0.
- Abort mid-collection: send 3 samples, assert `clear`, then 5 new samples 1/6, 2/6, 3/5, 4/5, 5/5. Required: a single `inference_done` with `inferred_type` = 6, and no stale entries from before the `clear`.
